clock_timekeeper: RTL and testbench
===================================

CLOCK_TIMEKEEPER -- requirements
Module: clock_timekeeper

Interface
REQ-001 Parameter TICKS_PER_SEC, default 1000: number of i_ms_pulse events per second; legal range 2..65535.
REQ-002 Parameter RESET_HR, default 0: hour value loaded at reset (0..23, 24h encoding).
REQ-003 i_clk  in  1  single clock; all state updates on its rising edge.
REQ-004 i_rstn  in  1  reset, asynchronous and active-low.
REQ-005 i_ms_pulse  in  1  one-cycle timebase tick.
REQ-006 i_set  in  1  one-cycle pulse; toggles between RUN and SET.
REQ-007 i_up, i_down  in  1 each  one-cycle pulses; adjust the selected field in SET.
REQ-008 i_left, i_right  in  1 each  one-cycle pulses; move the field selection in SET.
REQ-009 i_mode12  in  1  level input; 1 = 12-hour display, 0 = 24-hour display.
REQ-010 o_sec  out  6  seconds, 0..59.
REQ-011 o_min  out  6  minutes, 0..59.
REQ-012 o_hr  out  5  hours: 0..23 when i_mode12=0; 1..12 when i_mode12=1.
REQ-013 o_pm  out  1  1 when the internal hour is 12..23; valid in both modes.
REQ-014 o_set_mode  out  1  1 while in SET.
REQ-015 o_field  out  2  selected field: 0=SEC, 1=MIN, 2=HR; value 3 is never driven.
REQ-016 o_sec_tick  out  1  one-cycle pulse on every RUN-mode seconds increment.

Function
REQ-017 The hour SHALL be stored in 24h encoding; i_mode12 affects only o_hr, combinationally: hr 0 -> 12, 1..12 -> itself, 13..23 -> hr-12.
REQ-018 The sub-second counter SHALL be $clog2(TICKS_PER_SEC) bits wide and count 0..TICKS_PER_SEC-1.
REQ-019 In RUN, each i_ms_pulse SHALL increment the sub-second counter; at TICKS_PER_SEC-1 it SHALL wrap to 0 and increment seconds in the same edge.
REQ-020 Cascade: sec 59->0 increments min; min 59->0 increments hr; hr 23->0. The full cascade SHALL complete on a single edge, one cycle after the qualifying pulse.
REQ-021 o_sec_tick SHALL be asserted for exactly the cycle after the edge on which seconds incremented in RUN.
REQ-022 FSM states: RUN (reset state) and SET. An i_set pulse in RUN -> SET; an i_set pulse in SET -> RUN.
REQ-023 On entering SET, o_field SHALL be set to 0 (SEC).
REQ-024 In SET, i_ms_pulse SHALL be ignored, and the sub-second counter SHALL hold at 0.
REQ-025 On leaving SET, the sub-second counter SHALL be 0, so the first RUN second lasts a full TICKS_PER_SEC pulses.
REQ-026 In SET, i_right SHALL step the field SEC->MIN->HR->SEC, and i_left SHALL step HR->MIN->SEC->HR.
REQ-027 In SET, i_up SHALL increment the selected field and i_down SHALL decrement it, each with wrap at that field's own modulus (60 or 24), with no carry into or borrow from any other field.
REQ-028 i_up and i_down asserted together SHALL produce no change; i_left and i_right asserted together SHALL produce no change.
REQ-029 If i_set coincides with any adjust or select pulse, only the mode toggle SHALL take effect in that cycle.
REQ-030 In RUN, i_up, i_down, i_left and i_right SHALL be ignored.
REQ-031 All outputs SHALL be registered, except o_hr and o_pm, which are combinational decodes of the registered hour and i_mode12.

Reset
REQ-032 While i_rstn=0, the block SHALL be in state RUN with: sub-second counter=0, sec=0, min=0, hr=RESET_HR, o_field=0, o_set_mode=0, o_sec_tick=0.
REQ-033 Reset asserted mid-operation (in either state) SHALL take effect immediately and asynchronously; the first counting edge SHALL be the first rising edge after i_rstn deasserts.

Verification
REQ-034 Rollover: TICKS_PER_SEC=4; preload 23:59:59 via SET; return to RUN; apply 4 pulses -> 00:00:00, exactly one o_sec_tick, o_pm=0.
REQ-035 12h decode: hr=0 -> o_hr=12, o_pm=0; hr=13 -> o_hr=1, o_pm=1; hr=12 -> o_hr=12, o_pm=1; toggling i_mode12 changes only o_hr.
REQ-036 SET wrap with no carry: in SET with MIN selected at 59, i_up -> min=0 and hr unchanged; with SEC selected at 0, i_down -> sec=59 and min unchanged.
REQ-037 SET freeze: in SET, 10*TICKS_PER_SEC pulses -> sec/min/hr unchanged and no o_sec_tick; after exiting SET, the first o_sec_tick arrives after exactly TICKS_PER_SEC pulses.
REQ-038 Conflicts: i_up+i_down together -> no change; i_set+i_up together in SET -> state becomes RUN and the field value is unchanged; i_left from SEC -> HR.
REQ-039 Async reset: assert i_rstn=0 between clock edges during SET -> outputs reach reset values without waiting for a clock edge; o_hr=RESET_HR.

Source files
------------

// File: rtl/clock_timekeeper.sv
// clock_timekeeper: time-of-day counter (HH:MM:SS) driven by a sub-second timebase tick,
// with a SET mode for per-field adjustment and a combinational 12/24h hour decode.
module clock_timekeeper #(
   parameter int unsigned TICKS_PER_SEC = 1000,
   parameter int unsigned RESET_HR      = 0
) (
   input  logic       i_clk,
   input  logic       i_rstn,
   input  logic       i_ms_pulse,
   input  logic       i_set,
   input  logic       i_up,
   input  logic       i_down,
   input  logic       i_left,
   input  logic       i_right,
   input  logic       i_mode12,
   output logic [5:0] o_sec,
   output logic [5:0] o_min,
   output logic [4:0] o_hr,
   output logic       o_pm,
   output logic       o_set_mode,
   output logic [1:0] o_field,
   output logic       o_sec_tick
);

   localparam int unsigned SUB_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(TICKS_PER_SEC - 1);

   typedef enum logic {ST_RUN = 1'b0, ST_SET = 1'b1} state_e;
   typedef enum logic [1:0] {F_SEC = 2'd0, F_MIN = 2'd1, F_HR = 2'd2} field_e;

   state_e           state_q, state_d;
   field_e           field_q, field_d;
   logic [SUB_W-1:0] sub_q, sub_d;
   logic [5:0]       sec_q, sec_d;
   logic [5:0]       min_q, min_d;
   logic [4:0]       hr_q, hr_d;
   logic             tick_q, tick_d;
   logic [5:0]       hr_ext;

   assign hr_ext = {1'b0, hr_q};

   function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] top);
      return (v == top) ? 6'd0 : v + 6'd1;
   endfunction

   function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] top);
      return (v == 6'd0) ? top : v - 6'd1;
   endfunction

   // Next-state: i_set always wins; in SET the fields adjust independently with no carry
   always_comb begin
      state_d = state_q;
      field_d = field_q;
      sub_d   = sub_q;
      sec_d   = sec_q;
      min_d   = min_q;
      hr_d    = hr_q;
      tick_d  = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (i_set) begin
               state_d = ST_SET;
               field_d = F_SEC;
               sub_d   = '0;
            end else if (i_ms_pulse) begin
               if (sub_q == SUB_MAX) begin
                  sub_d  = '0;
                  tick_d = 1'b1;
                  sec_d  = wrap_inc(sec_q, 6'd59);
                  if (sec_q == 6'd59) begin
                     min_d = wrap_inc(min_q, 6'd59);
                     if (min_q == 6'd59) hr_d = 5'(wrap_inc(hr_ext, 6'd23));
                  end
               end else begin
                  sub_d = sub_q + SUB_W'(1);
               end
            end
         end
         ST_SET: begin
            sub_d = '0;
            if (i_set) begin
               state_d = ST_RUN;
            end else begin
               if (i_right && !i_left) begin
                  case (field_q)
                     F_SEC:   field_d = F_MIN;
                     F_MIN:   field_d = F_HR;
                     default: field_d = F_SEC;
                  endcase
               end else if (i_left && !i_right) begin
                  case (field_q)
                     F_SEC:   field_d = F_HR;
                     F_HR:    field_d = F_MIN;
                     default: field_d = F_SEC;
                  endcase
               end
               if (i_up ^ i_down) begin
                  case (field_q)
                     F_SEC:   sec_d = i_up ? wrap_inc(sec_q, 6'd59) : wrap_dec(sec_q, 6'd59);
                     F_MIN:   min_d = i_up ? wrap_inc(min_q, 6'd59) : wrap_dec(min_q, 6'd59);
                     F_HR:    hr_d  = i_up ? 5'(wrap_inc(hr_ext, 6'd23)) : 5'(wrap_dec(hr_ext, 6'd23));
                     default: ;
                  endcase
               end
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q <= ST_RUN;
         field_q <= F_SEC;
         sub_q   <= '0;
         sec_q   <= '0;
         min_q   <= '0;
         hr_q    <= 5'(RESET_HR);
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         field_q <= field_d;
         sub_q   <= sub_d;
         sec_q   <= sec_d;
         min_q   <= min_d;
         hr_q    <= hr_d;
         tick_q  <= tick_d;
      end
   end

   // Hour is kept in 24h form; 12h mode only changes how it is presented
   always_comb begin
      o_pm = (hr_q >= 5'd12);
      o_hr = hr_q;
      if (i_mode12) begin
         if (hr_q == 5'd0)       o_hr = 5'd12;
         else if (hr_q > 5'd12)  o_hr = hr_q - 5'd12;
      end
   end

   assign o_sec      = sec_q;
   assign o_min      = min_q;
   assign o_set_mode = (state_q == ST_SET);
   assign o_field    = field_q;
   assign o_sec_tick = tick_q;

endmodule

// File: tb/tb_clock_timekeeper.sv
// Scoreboarded bench for clock_timekeeper: a seconds-of-day reference model pushes the
// expected outputs per cycle; a monitor pops and compares after each rising edge.
module tb_clock_timekeeper;

   localparam int unsigned TPS = 4;
   localparam int unsigned RHR = 13;

   logic       clk, rstn;
   logic       ms, set, up, dn, lf, rt, mode12;
   logic [5:0] o_sec, o_min;
   logic [4:0] o_hr;
   logic       o_pm, o_set_mode, o_sec_tick;
   logic [1:0] o_field;

   clock_timekeeper #(.TICKS_PER_SEC(TPS), .RESET_HR(RHR)) dut (
      .i_clk(clk), .i_rstn(rstn), .i_ms_pulse(ms), .i_set(set), .i_up(up), .i_down(dn),
      .i_left(lf), .i_right(rt), .i_mode12(mode12),
      .o_sec(o_sec), .o_min(o_min), .o_hr(o_hr), .o_pm(o_pm), .o_set_mode(o_set_mode),
      .o_field(o_field), .o_sec_tick(o_sec_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int sec; int min; int hr; int pm; int set; int field; int tick;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   // reference model: time of day as a seconds count
   int m_tod, m_sub, m_field, m_set, m_tick, m_mode;

   task automatic check(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d at %0t", name, got, want, $time);
      end
   endtask

   task automatic model_reset();
      m_tod = RHR * 3600; m_sub = 0; m_field = 0; m_set = 0; m_tick = 0;
   endtask

   task automatic model_step(input bit ms_v, set_v, up_v, dn_v, l_v, r_v);
      int h, mi, s, d, f;
      m_tick = 0;
      f = m_field;
      if (set_v) begin
         m_set = m_set ? 0 : 1;
         m_sub = 0;
         if (m_set != 0) m_field = 0;
      end else if (m_set == 0) begin
         if (ms_v) begin
            m_sub++;
            if (m_sub == TPS) begin
               m_sub  = 0;
               m_tod  = (m_tod + 1) % 86400;
               m_tick = 1;
            end
         end
      end else begin
         if (l_v && !r_v) m_field = (m_field + 2) % 3;
         if (r_v && !l_v) m_field = (m_field + 1) % 3;
         if (up_v != dn_v) begin
            d  = up_v ? 1 : -1;
            h  = m_tod / 3600;
            mi = (m_tod / 60) % 60;
            s  = m_tod % 60;
            if (f == 0) s  = (s + 60 + d) % 60;
            if (f == 1) mi = (mi + 60 + d) % 60;
            if (f == 2) h  = (h + 24 + d) % 24;
            m_tod = h * 3600 + mi * 60 + s;
         end
      end
   endtask

   task automatic push_expected();
      exp_t e;
      int h;
      h = m_tod / 3600;
      e.sec   = m_tod % 60;
      e.min   = (m_tod / 60) % 60;
      e.hr    = (m_mode != 0) ? ((h % 12 == 0) ? 12 : h % 12) : h;
      e.pm    = (h >= 12) ? 1 : 0;
      e.set   = m_set;
      e.field = m_field;
      e.tick  = m_tick;
      q.push_back(e);
   endtask

   task automatic cyc(input bit ms_v, set_v, up_v, dn_v, l_v, r_v);
      @(negedge clk);
      ms = ms_v; set = set_v; up = up_v; dn = dn_v; lf = l_v; rt = r_v;
      mode12 = m_mode[0];
      model_step(ms_v, set_v, up_v, dn_v, l_v, r_v);
      push_expected();
   endtask

   task automatic tidle(); cyc(0, 0, 0, 0, 0, 0); endtask
   task automatic tms();   cyc(1, 0, 0, 0, 0, 0); endtask
   task automatic tset();  cyc(0, 1, 0, 0, 0, 0); endtask
   task automatic tup();   cyc(0, 0, 1, 0, 0, 0); endtask
   task automatic tdn();   cyc(0, 0, 0, 1, 0, 0); endtask
   task automatic tl();    cyc(0, 0, 0, 0, 1, 0); endtask
   task automatic tr();    cyc(0, 0, 0, 0, 0, 1); endtask

   task automatic drain();
      tidle();
      @(posedge clk);
      #3;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_sec"},   int'(o_sec), 0);
      check({tag, "_min"},   int'(o_min), 0);
      check({tag, "_hr"},    int'(o_hr), RHR);
      check({tag, "_pm"},    int'(o_pm), 1);
      check({tag, "_set"},   int'(o_set_mode), 0);
      check({tag, "_field"}, int'(o_field), 0);
      check({tag, "_tick"},  int'(o_sec_tick), 0);
   endtask

   // monitor: one expected snapshot per driven edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("sec",   int'(o_sec), e.sec);
            check("min",   int'(o_min), e.min);
            check("hr",    int'(o_hr), e.hr);
            check("pm",    int'(o_pm), e.pm);
            check("set",   int'(o_set_mode), e.set);
            check("field", int'(o_field), e.field);
            check("tick",  int'(o_sec_tick), e.tick);
         end
      end
   end

   initial begin
      rstn = 1'b0; ms = 0; set = 0; up = 0; dn = 0; lf = 0; rt = 0; mode12 = 0;
      m_mode = 0;
      model_reset();
      #12;
      check_reset_vals("rst");
      @(negedge clk);
      rstn = 1'b1;

      // preload 23:59:59, exercising SEC/MIN wrap on decrement without borrow
      tset(); tdn(); tr(); tdn(); tr();
      for (int i = 0; i < 10; i++) tup();
      tset();
      for (int i = 0; i < 4; i++) begin tms(); tidle(); end

      // 12h decode at hr 0, 12, 13 and mode toggling
      m_mode = 1; tidle();
      tset(); tl();
      for (int i = 0; i < 13; i++) tup();
      m_mode = 0; tidle();
      m_mode = 1; tidle();

      // MIN wrap up with no carry, then conflicting inputs
      tl(); tdn(); tup();
      cyc(0, 0, 1, 1, 0, 0);
      cyc(0, 0, 0, 0, 1, 1);
      cyc(0, 1, 1, 0, 0, 0);

      // SET freeze and full first second after exit
      tset();
      for (int i = 0; i < 10 * TPS; i++) tms();
      tset();
      for (int i = 0; i < 2 * TPS; i++) begin tms(); tidle(); end

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 63) == 0) m_mode = m_mode ^ 1;
         cyc($urandom_range(0, 9) < 5, $urandom_range(0, 39) == 0,
             $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      end

      // asynchronous reset between edges while in SET
      m_mode = 0;
      tidle();
      if (m_set == 0) tset();
      tup(); tr(); tup();
      drain();
      rstn = 1'b0;
      #1;
      check_reset_vals("arst");
      @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      model_reset();
      for (int i = 0; i < 3 * TPS; i++) tms();

      drain();
      check("queue_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
